ens_layer_pipe_skid: RTL and testbench

ENS_LAYER_PIPE_SKID -- requirements
Module: ens_layer_pipe_skid

---
 rtl/ens_layer_pipe_skid.sv | 98 +++++++++
 tb/tb_ens_layer_pipe_skid.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ens_layer_pipe_skid.sv
// Two-entry skid buffer between neuron LUT layers. The input-side ready is
// registered so no combinational path runs from m_ready back to s_ready.
module ens_layer_pipe_skid #(
  parameter int WIDTH = 256,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] xfer_count
);

  // Encoding equals the number of held vectors, so occupancy exposes the state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  // Handshake: a transfer happens on a cycle where valid and ready are both 1
  // at the rising edge; valid never waits on ready, and s_ready is a flop.

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             s_ready_q, s_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_xfer, out_xfer;

  assign m_valid    = (state_q != EMPTY);
  assign m_data     = main_q;
  assign s_ready    = s_ready_q;
  assign occupancy  = state_q;
  assign xfer_count = cnt_q;

  assign in_xfer  = s_valid & s_ready_q;
  assign out_xfer = m_valid & m_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_d  = s_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = s_data;
        end else if (in_xfer) begin
          skid_d  = s_data;
          state_d = TWO;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (out_xfer && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    // Ready for next cycle is decided from where the state is going.
    s_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      s_ready_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      s_ready_q <= s_ready_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ens_layer_pipe_skid.sv
// Bench for ens_layer_pipe_skid: FIFO-of-two reference model with scoreboard,
// directed scenarios, random valid/ready traffic and a small saturating instance.
module tb_ens_layer_pipe_skid;

  localparam int W  = 256;
  localparam int W2 = 8;
  localparam int CW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic [W-1:0]  s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [1:0]    occupancy;
  logic [CW-1:0] xfer_count;

  // small instance for counter saturation
  logic [W2-1:0] s2_data = '0;
  logic          s2_valid = 1'b0;
  logic          s2_ready;
  logic [W2-1:0] m2_data;
  logic          m2_valid;
  logic          m2_ready = 1'b0;
  logic [1:0]    occupancy2;
  logic [3:0]    xfer_count2;

  ens_layer_pipe_skid #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .occupancy(occupancy), .xfer_count(xfer_count)
  );

  ens_layer_pipe_skid #(.WIDTH(W2), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .s_data(s2_data), .s_valid(s2_valid), .s_ready(s2_ready),
    .m_data(m2_data), .m_valid(m2_valid), .m_ready(m2_ready),
    .occupancy(occupancy2), .xfer_count(xfer_count2)
  );

  // ---------------- scoreboard / model ----------------
  logic [W-1:0] exp_q[$];
  logic         exp_s_ready = 1'b0;
  int           exp_cnt = 0;
  int           n_tests = 0;
  int           n_fail = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".m_valid"}, W'(m_valid), W'(exp_q.size() > 0));
    check_eq({tag, ".occ"}, W'(occupancy), W'(exp_q.size()));
    check_eq({tag, ".s_ready"}, W'(s_ready), W'(exp_s_ready));
    check_eq({tag, ".xfer"}, W'(xfer_count), W'(exp_cnt));
    if (exp_q.size() > 0) check_eq({tag, ".m_data"}, m_data, exp_q[0]);
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; drives inputs, predicts, advances one clock, checks.
  task automatic cycle(input string tag, input logic sv, input logic [W-1:0] sd, input logic mr);
    logic in_x, out_x;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    in_x  = sv && exp_s_ready && (exp_q.size() < 2);
    out_x = mr && (exp_q.size() > 0);
    @(posedge clk);
    #1;
    if (out_x) begin
      void'(exp_q.pop_front());
      if (exp_cnt < (1 << CW) - 1) exp_cnt++;
    end
    if (in_x) exp_q.push_back(sd);
    exp_s_ready = (exp_q.size() < 2);
    check_outputs(tag);
  endtask

  // Asserts reset away from the clock edge, checks clearing, releases.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = {8{32'hDEAD_BEEF}};
    #1;
    exp_q.delete();
    exp_cnt     = 0;
    exp_s_ready = 1'b0;
    check_outputs({tag, ".async"});
    repeat (2) @(posedge clk);
    #1;
    check_outputs({tag, ".held"});
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_s_ready = 1'b1;
    check_outputs({tag, ".rel"});
  endtask

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] v1, v2, v3;
    int outs2, size2, cyc;
    logic rdy2;

    // reset state while rst_n is low from time 0
    #2;
    check_outputs("reset0");
    do_reset("reset1");

    // single vector
    v1 = '0;
    v1[7:0] = 8'hA5;
    cycle("single.push", 1'b1, v1, 1'b1);
    check_eq("single.data", m_data, v1);
    cycle("single.pop", 1'b0, '0, 1'b1);
    check_eq("single.cnt", W'(xfer_count), W'(1));

    // backpressure
    v1 = rand_vec();
    v2 = rand_vec();
    v3 = rand_vec();
    cycle("bp.v1", 1'b1, v1, 1'b0);
    cycle("bp.v2", 1'b1, v2, 1'b0);
    check_eq("bp.occ2", W'(occupancy), W'(2));
    cycle("bp.hold", 1'b1, v3, 1'b0);
    check_eq("bp.stable", m_data, v1);
    check_eq("bp.sready0", W'(s_ready), W'(0));
    cycle("bp.out1", 1'b0, '0, 1'b1);
    check_eq("bp.second", m_data, v2);
    cycle("bp.out2", 1'b0, '0, 1'b1);
    check_eq("bp.empty", W'(occupancy), W'(0));

    // streaming with incrementing patterns
    for (int i = 0; i < 100; i++) cycle("stream", 1'b1, W'(i + 1), 1'b1);
    cycle("stream.drain", 1'b0, '0, 1'b1);
    check_eq("stream.cnt", W'(xfer_count), W'(103));

    // random valid/ready
    for (int i = 0; i < 10000; i++) begin
      cycle("rand", ($urandom_range(0, 3) != 0), rand_vec(), ($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 3; i++) cycle("rand.drain", 1'b0, '0, 1'b1);
    check_eq("rand.empty", W'(exp_q.size()), W'(0));

    // reset while holding two vectors
    v1 = rand_vec();
    v2 = rand_vec();
    v3 = rand_vec();
    cycle("rst2.v1", 1'b1, v1, 1'b0);
    cycle("rst2.v2", 1'b1, v2, 1'b0);
    check_eq("rst2.full", W'(occupancy), W'(2));
    do_reset("rst2");
    cycle("rst2.v3", 1'b1, v3, 1'b0);
    check_eq("rst2.first", m_data, v3);
    cycle("rst2.pop", 1'b0, '0, 1'b1);

    // counter saturation on the 4-bit instance
    s2_valid = 1'b1;
    m2_ready = 1'b1;
    outs2 = 0;
    size2 = occupancy2 == 2'd0 ? 0 : 0;
    rdy2  = 1'b1;
    cyc   = 0;
    while (outs2 < 20 && cyc < 100) begin
      logic i2, o2;
      s2_data = W2'($urandom);
      i2 = rdy2 && (size2 < 2);
      o2 = (size2 > 0);
      @(posedge clk);
      #1;
      if (o2) begin
        outs2++;
        size2--;
      end
      if (i2) size2++;
      rdy2 = (size2 < 2);
      cyc++;
      check_eq("sat.cnt", W'(xfer_count2), W'((outs2 > 15) ? 15 : outs2));
    end
    s2_valid = 1'b0;
    if (cyc >= 100) check_eq("sat.timeout", W'(cyc), W'(0));
    check_eq("sat.final", W'(xfer_count2), W'(15));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
